sram_packet_reader: RTL
=======================

// Module: sram_packet_reader
// PURPOSE
// Read-side counterpart of the SRAM write interface. It walks one packet's page chain through the jump table,
// starting at the head page. For each page it fetches 8 halfwords plus the page ECC code, then corrects the page
// through sram_ecc_decoder. It streams the packet out as 16-bit words and returns each drained page to the free list.
// PARAMETERS
// DW      16  data word width
// PAGE_AW 11  page index width (2048 pages per SRAM)
// ECC_W   8   ECC code width per page
// PORTS
// clk              in   1       clock
// rst_n            in   1       synchronous active-low reset
// rd_start         in   1       start pulse; sampled only in IDLE
// rd_head_addr     in   16      {sram_idx[4:0], head_page[10:0]}; low 11 bits used
// rd_tail_addr     in   16      {sram_idx, tail_page}; low 11 bits used
// rd_busy          out  1       high from the cycle after accepted rd_start until IDLE
// sram_rd_en       out  1       data SRAM read strobe; 1-cycle read latency
// sram_rd_addr     out  14      {page, word[2:0]}
// sram_dout        in   16      read data
// jt_rd_addr       out  11      jump-table address; jt_dout[10:0] = next page, 1-cycle latency
// jt_dout          in   16      jump-table read data
// ec_rd_addr       out  11      ECC RAM address; 1-cycle latency
// ec_dout          in   8       ECC code read data
// np_free_vld      out  1       page-release strobe to the null-page FIFO
// np_free_page     out  11      page being released
// rd_xfer_data_vld out  1       output word valid (no backpressure)
// rd_xfer_data     out  16      corrected output word
// rd_end_of_packet out  1       asserted with the final word
// rd_ecc_corrected out  1       1-cycle pulse: decoder fixed a single-bit error on this page
// rd_ecc_fatal     out  1       1-cycle pulse: uncorrectable error; data still emitted uncorrected
// BEHAVIOUR
// - Reset: every output is 0, state is IDLE, and buffers are don't-care. Reset mid-packet aborts without releasing the page.
// - States: IDLE -> FETCH(k=0..7) -> CAP -> DEC -> EMIT(n words) -> FETCH (next page) | IDLE (last page).
// - rd_start in IDLE at cycle T: latch page and tail_page. FETCH runs T+1..T+8.
// - FETCH issues sram_rd_en with addr {page,k} at cycle k.
// - At FETCH k=0 also drive jt_rd_addr=ec_rd_addr=page. Capture next_page=jt_dout[10:0] and code=ec_dout at k=1.
// - sram_dout for word k lands one cycle later; word k goes to buf[k]. CAP captures word 7.
// - First page only: raw word0 gives L=buf0[15:7] (packet halfwords). Last-page count lc = (L[2:0]==0) ? 8 : L[2:0].
// - Last page is the page where page==tail_page. It has n=lc words; every other page has n=8.
// - DEC: zero buf[k] for k>=n, matching the encoder's zero fill. Feed buf and code to the decoder; register the corrected words.
// - DEC also pulses np_free_vld with np_free_page=page, plus rd_ecc_corrected or rd_ecc_fatal if the decoder flags one.
// - EMIT: rd_xfer_data_vld=1 for n consecutive cycles, words 0..n-1. rd_end_of_packet is set on the final word of the last page.
// - After EMIT, a non-last page sets page<=next_page and re-enters FETCH. A last page returns to IDLE and drops rd_busy.
// - Per-page cycle cost is 10+n. Single-page packet: first word at T+11.
// - rd_start while busy is ignored. head==tail is a single-page packet.
// - No fetch/emit overlap in this revision: sram_rd_en is never high during EMIT.
// STRUCTURE
// - Shared package sram_pkg holds: PAGE_WORDS=8, PAGE_AW, DW, ECC_W, and the state enum typedef rd_state_t.
// - Sub-module sram_ecc_decoder, combinational. Inputs: data_0..7, code. Outputs: out_0..7, single_err, double_err.
// - Everything else (FSM, word counter, buffers) lives inline.
// TESTING
// - Single-page packet, 5 words, header L=5, head=tail=0x003 -> 5 words at T+11..T+15, EOP on 5th, np_free_page=3 at T+10.
// - 3-page packet, L=20, chain 0x010->0x011->0x012 -> 8+8+4 words, free pulses for 0x010/0x011/0x012, EOP on the 20th word.
// - L=16 exact multiple -> last page emits 8 words (lc=8), no zero-fill, correct EOP.
// - Flip 1 bit of word 2 in memory -> corrected word output, one rd_ecc_corrected pulse. Two flips -> rd_ecc_fatal pulse.
// - rd_start pulsed again mid-packet -> ignored, stream intact. rd_start at the IDLE return cycle -> accepted.
// - rst_n low during EMIT -> all outputs 0 next cycle, rd_busy=0, no np_free_vld. Then a new packet reads correctly.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the SRAM packet read path.
`default_nettype none

package sram_pkg;

   localparam int PAGE_WORDS = 8;
   localparam int PAGE_AW    = 11;
   localparam int DW         = 16;
   localparam int ECC_W      = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_CAP   = 3'd2,
      ST_DEC   = 3'd3,
      ST_EMIT  = 3'd4
   } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_ecc_decoder.sv
// Page ECC check/correct: code = {parity of all 128 bits, XOR of the indices of all set bits}.
// Any single data-bit flip is located; any two data-bit flips leave parity clean with a nonzero syndrome.
`default_nettype none

module sram_ecc_decoder
   import sram_pkg::*;
(
   input  logic [DW-1:0]    data_0,
   input  logic [DW-1:0]    data_1,
   input  logic [DW-1:0]    data_2,
   input  logic [DW-1:0]    data_3,
   input  logic [DW-1:0]    data_4,
   input  logic [DW-1:0]    data_5,
   input  logic [DW-1:0]    data_6,
   input  logic [DW-1:0]    data_7,
   input  logic [ECC_W-1:0] code,
   output logic [DW-1:0]    out_0,
   output logic [DW-1:0]    out_1,
   output logic [DW-1:0]    out_2,
   output logic [DW-1:0]    out_3,
   output logic [DW-1:0]    out_4,
   output logic [DW-1:0]    out_5,
   output logic [DW-1:0]    out_6,
   output logic [DW-1:0]    out_7,
   output logic             single_err,
   output logic             double_err
);

   localparam int BITS  = PAGE_WORDS * DW;
   localparam int POS_W = ECC_W - 1;

   logic [BITS-1:0]  flat;
   logic [BITS-1:0]  fixed;
   logic             par;
   logic [POS_W-1:0] pos;
   logic [POS_W-1:0] syn;

   assign flat = {data_7, data_6, data_5, data_4, data_3, data_2, data_1, data_0};

   always_comb begin
      par = 1'b0;
      pos = '0;
      for (int i = 0; i < BITS; i++) begin
         if (flat[i]) begin
            par = ~par;
            pos = pos ^ POS_W'(i);
         end
      end
   end

   assign syn        = pos ^ code[POS_W-1:0];
   assign single_err = par ^ code[ECC_W-1];
   assign double_err = ~single_err & (|syn);
   assign fixed      = flat ^ (single_err ? (BITS'(1) << syn) : '0);

   assign out_0 = fixed[0*DW +: DW];
   assign out_1 = fixed[1*DW +: DW];
   assign out_2 = fixed[2*DW +: DW];
   assign out_3 = fixed[3*DW +: DW];
   assign out_4 = fixed[4*DW +: DW];
   assign out_5 = fixed[5*DW +: DW];
   assign out_6 = fixed[6*DW +: DW];
   assign out_7 = fixed[7*DW +: DW];

endmodule

`default_nettype wire

// File: rtl/sram_packet_reader.sv
// Walks a packet's page chain, fetches and ECC-corrects each page, streams its words and frees the page.
`default_nettype none

module sram_packet_reader
   import sram_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rd_start,
   input  logic [15:0]        rd_head_addr,
   input  logic [15:0]        rd_tail_addr,
   output logic               rd_busy,
   output logic               sram_rd_en,
   output logic [PAGE_AW+2:0] sram_rd_addr,
   input  logic [DW-1:0]      sram_dout,
   output logic [PAGE_AW-1:0] jt_rd_addr,
   input  logic [15:0]        jt_dout,
   output logic [PAGE_AW-1:0] ec_rd_addr,
   input  logic [ECC_W-1:0]   ec_dout,
   output logic               np_free_vld,
   output logic [PAGE_AW-1:0] np_free_page,
   output logic               rd_xfer_data_vld,
   output logic [DW-1:0]      rd_xfer_data,
   output logic               rd_end_of_packet,
   output logic               rd_ecc_corrected,
   output logic               rd_ecc_fatal
);

   rd_state_t          state_q;
   logic [2:0]         k_q;
   logic [3:0]         cnt_q;
   logic [3:0]         lc_q;
   logic               first_q;
   logic [PAGE_AW-1:0] page_q, tail_q, next_q;
   logic [ECC_W-1:0]   code_q;
   logic [DW-1:0]      buf_q [PAGE_WORDS];

   logic               busy_q, rd_en_q, free_vld_q, vld_q, eop_q, corr_q, fatal_q;
   logic [PAGE_AW+2:0] rd_addr_q;
   logic [PAGE_AW-1:0] tab_addr_q, free_page_q;
   logic [DW-1:0]      data_q;

   logic               last_page;
   logic [3:0]         page_n;
   logic [DW-1:0]      din  [PAGE_WORDS];
   logic [DW-1:0]      dout [PAGE_WORDS];
   logic               single_err, double_err;
   logic               unused_w;

   assign unused_w  = ^{rd_head_addr[15:PAGE_AW], rd_tail_addr[15:PAGE_AW], jt_dout[15:PAGE_AW]};
   assign last_page = (page_q == tail_q);
   assign page_n    = last_page ? lc_q : 4'(PAGE_WORDS);

   // Word 7 is decoded straight off the RAM port so the flags line up with the page release.
   for (genvar K = 0; K < PAGE_WORDS; K++) begin : g_din
      if (K == PAGE_WORDS - 1) begin : g_tail
         assign din[K] = (page_n == 4'(PAGE_WORDS)) ? sram_dout : '0;
      end else begin : g_body
         assign din[K] = (4'(K) < page_n) ? buf_q[K] : '0;
      end
   end

   sram_ecc_decoder u_dec (
      .data_0(din[0]), .data_1(din[1]), .data_2(din[2]), .data_3(din[3]),
      .data_4(din[4]), .data_5(din[5]), .data_6(din[6]), .data_7(din[7]),
      .code(code_q),
      .out_0(dout[0]), .out_1(dout[1]), .out_2(dout[2]), .out_3(dout[3]),
      .out_4(dout[4]), .out_5(dout[5]), .out_6(dout[6]), .out_7(dout[7]),
      .single_err(single_err), .double_err(double_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         cnt_q       <= '0;
         lc_q        <= '0;
         first_q     <= 1'b0;
         page_q      <= '0;
         tail_q      <= '0;
         next_q      <= '0;
         code_q      <= '0;
         busy_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         tab_addr_q  <= '0;
         free_vld_q  <= 1'b0;
         free_page_q <= '0;
         vld_q       <= 1'b0;
         data_q      <= '0;
         eop_q       <= 1'b0;
         corr_q      <= 1'b0;
         fatal_q     <= 1'b0;
      end else begin
         free_vld_q <= 1'b0;
         corr_q     <= 1'b0;
         fatal_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rd_start) begin
                  page_q     <= rd_head_addr[PAGE_AW-1:0];
                  tail_q     <= rd_tail_addr[PAGE_AW-1:0];
                  first_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  k_q        <= '0;
                  rd_en_q    <= 1'b1;
                  rd_addr_q  <= {rd_head_addr[PAGE_AW-1:0], 3'd0};
                  tab_addr_q <= rd_head_addr[PAGE_AW-1:0];
                  state_q    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (k_q != 3'd0) buf_q[k_q - 3'd1] <= sram_dout;
               if (k_q == 3'd1) begin
                  next_q <= jt_dout[PAGE_AW-1:0];
                  code_q <= ec_dout;
                  // Raw header word: length L sits in [15:7]; only L mod 8 matters.
                  if (first_q) lc_q <= (sram_dout[9:7] == 3'd0) ? 4'd8 : {1'b0, sram_dout[9:7]};
               end
               if (k_q == 3'd7) begin
                  rd_en_q <= 1'b0;
                  state_q <= ST_CAP;
               end else begin
                  k_q       <= k_q + 3'd1;
                  rd_addr_q <= {page_q, k_q + 3'd1};
               end
            end
            ST_CAP: begin
               for (int i = 0; i < PAGE_WORDS; i++) buf_q[i] <= dout[i];
               free_vld_q  <= 1'b1;
               free_page_q <= page_q;
               corr_q      <= single_err;
               fatal_q     <= double_err;
               state_q     <= ST_DEC;
            end
            ST_DEC: begin
               vld_q   <= 1'b1;
               data_q  <= buf_q[0];
               eop_q   <= last_page && (page_n == 4'd1);
               cnt_q   <= 4'd1;
               first_q <= 1'b0;
               state_q <= ST_EMIT;
            end
            ST_EMIT: begin
               if (cnt_q != page_n) begin
                  vld_q  <= 1'b1;
                  data_q <= buf_q[cnt_q[2:0]];
                  eop_q  <= last_page && (cnt_q == page_n - 4'd1);
                  cnt_q  <= cnt_q + 4'd1;
               end else begin
                  vld_q <= 1'b0;
                  eop_q <= 1'b0;
                  if (last_page) begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     page_q     <= next_q;
                     k_q        <= '0;
                     rd_en_q    <= 1'b1;
                     rd_addr_q  <= {next_q, 3'd0};
                     tab_addr_q <= next_q;
                     state_q    <= ST_FETCH;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_busy          = busy_q;
   assign sram_rd_en       = rd_en_q;
   assign sram_rd_addr     = rd_addr_q;
   assign jt_rd_addr       = tab_addr_q;
   assign ec_rd_addr       = tab_addr_q;
   assign np_free_vld      = free_vld_q;
   assign np_free_page     = free_page_q;
   assign rd_xfer_data_vld = vld_q;
   assign rd_xfer_data     = data_q;
   assign rd_end_of_packet = eop_q;
   assign rd_ecc_corrected = corr_q;
   assign rd_ecc_fatal     = fatal_q;

endmodule

`default_nettype wire
